console_sr_regs: RTL and testbench
==================================

// Module: console_sr_regs
// PURPOSE
//  Console switch/display register for the I/O page. Serves one I/O-page word (default 17570).
//  Reads return a synchronised, debounced copy of the front-panel switches.
//  Writes load a display (lights) register; word and byte writes are supported.
//  Sits on the iopage bus beside the other *_regs blocks; its decode output feeds the
//  bus read-data mux.
// PARAMETERS
//  DATA_W      16        switch/display/data width (even, >=8)
//  ADDR_W      13        iopage_addr width
//  REG_ADDR    13'o17570 word address decoded; iopage_addr[0] ignored for decode
//  DEBOUNCE    1023      stable cycles required before a switch change is accepted; 0 = no debounce
// PORTS
//  clk             in   1       system clock
//  reset_n         in   1       asynchronous, active-low reset
//  iopage_addr     in   ADDR_W  I/O page address
//  data_in         in   DATA_W  write data, lane-aligned
//  iopage_rd       in   1       read strobe
//  iopage_wr       in   1       write strobe
//  iopage_byte_op  in   1       byte access; iopage_addr[0] selects lane (0=low, 1=high)
//  data_out        out  DATA_W  read data; 0 when not decoded
//  decode          out  1       iopage_addr[ADDR_W-1:1] == REG_ADDR[ADDR_W-1:1]
//  switches        in   DATA_W  raw front-panel switches, asynchronous to clk
//  display         out  DATA_W  display register contents
//  display_strobe  out  1       1-cycle pulse, the cycle after an accepted write
//  sw_change       out  1       1-cycle pulse when the debounced switch value changes
// BEHAVIOUR
//  Reset (async assert, sync release): sync flops, candidate, counter, sw_stable, display = 0;
//    display_strobe = 0, sw_change = 0. data_out = 0 and decode follows the address combinationally.
//  Sync: switches pass through 2 flops -> sw_sync. Every bit is sampled; no metastability-based gating.
//  Debounce (DEBOUNCE>0), per clock:
//   - sw_sync != candidate: candidate <= sw_sync, cnt <= 0.
//   - else if cnt == DEBOUNCE and sw_stable != candidate: sw_stable <= candidate, sw_change pulses next cycle.
//   - else if cnt < DEBOUNCE: cnt++. cnt saturates at DEBOUNCE; it never wraps.
//   - Width of cnt = $clog2(DEBOUNCE+1).
//   - A bounce mid-count restarts the count, so a glitch never reaches sw_stable.
//   - Latency from a clean edge on switches: 2 (sync) + 1 (candidate load) + DEBOUNCE + 1 cycles.
//  DEBOUNCE==0: sw_stable <= sw_sync every cycle; sw_change pulses on any difference.
//  Read: data_out = decode ? sw_stable : 0. Combinational, zero latency, independent of iopage_rd.
//    Byte reads return the full word; the bus master selects the lane.
//  Write: on posedge clk with iopage_wr && decode:
//   - word: display <= data_in.
//   - byte, addr[0]=0: display[7:0] <= data_in[7:0]; upper byte unchanged.
//   - byte, addr[0]=1: display[DATA_W-1:8] <= data_in[DATA_W-1:8]; low byte unchanged.
//   - display_strobe = 1 in the following cycle only; back-to-back writes give back-to-back pulses.
//   - Writes with decode=0 are ignored; no strobe.
//  Simultaneous rd+wr: the read returns switches; the write updates display. The two are independent.
//  A write never alters the switch path; a switch change never alters display.
//  Reset mid-debounce discards the candidate; sw_stable returns to 0 with no sw_change pulse.
// STRUCTURE
//  console_pkg: CONSOLE_SR_ADDR = 13'o17570, lane-select helper constants.
//  Sub-module sr_debounce #(W, DEBOUNCE) (clk, reset_n, d_async, q_stable, changed):
//    contains the synchroniser, candidate, counter and sw_stable.
//  The top level holds decode, the read mux, the display register and the strobe.
// TESTING
//  1 Reset: reset_n=0 mid-traffic -> display=0, data_out=0, no strobes; release -> still 0.
//  2 Read: switches=16'o123456, wait 2+1+DEBOUNCE+1 cycles, addr=17570 -> data_out=123456,
//    one sw_change pulse. addr=17572 -> decode=0, data_out=0.
//  3 Bounce: DEBOUNCE=8; toggle bit0 every 5 cycles x4, then hold -> sw_stable changes once,
//    exactly 12 cycles after the last toggle.
//  4 Word write 16'o177777 -> display=177777, strobe 1 cycle.
//    Byte write addr=17571, data_in=16'o052000 -> display=052377.
//  5 Byte write addr=17570, data_in=16'h00A5, display=16'hFF00 -> display=16'hFFA5.
//    Write to 17566 -> display unchanged, no strobe.
//  6 Same-cycle rd+wr and DEBOUNCE=0 build: data_out=switches after 3 cycles, display updated,
//    both pulses correct.

Source files
------------

// File: rtl/console_pkg.sv
// Shared constants and write-lane classification for the console switch/display register.
package console_pkg;

    localparam logic [12:0] CONSOLE_SR_ADDR = 13'o17570;

    // Byte-lane selectors carried on iopage_addr[0].
    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;
    localparam int   LANE_W  = 8;

    typedef enum logic [1:0] {
        WR_NONE,
        WR_WORD,
        WR_LO,
        WR_HI
    } wr_kind_e;

    function automatic wr_kind_e wr_kind(input logic wr_hit, input logic byte_op, input logic lane);
        if (!wr_hit)  return WR_NONE;
        if (!byte_op) return WR_WORD;
        return (lane == LANE_HI) ? WR_HI : WR_LO;
    endfunction

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for the front-panel switches.
module sr_debounce #(
    parameter int W        = 16,
    parameter int DEBOUNCE = 1023
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d_async,
    output logic [W-1:0] q_stable,
    output logic         changed
);

    logic [W-1:0] sw_meta;
    logic [W-1:0] sw_sync;

    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= d_async;
            sw_sync <= sw_meta;
        end
    end

    if (DEBOUNCE > 0) begin : g_debounce
        localparam int CNT_W = $clog2(DEBOUNCE + 1);
        localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

        logic [W-1:0]     candidate;
        logic [CNT_W-1:0] cnt;

        // Any disagreement with the candidate restarts the count, so a bounce never reaches q_stable.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                candidate <= '0;
                cnt       <= '0;
                q_stable  <= '0;
                changed   <= 1'b0;
            end else begin
                changed <= 1'b0;
                if (sw_sync != candidate) begin
                    candidate <= sw_sync;
                    cnt       <= '0;
                end else if (cnt == CNT_MAX && q_stable != candidate) begin
                    q_stable <= candidate;
                    changed  <= 1'b1;
                end else if (cnt < CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end else begin : g_passthru
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                q_stable <= '0;
                changed  <= 1'b0;
            end else begin
                q_stable <= sw_sync;
                changed  <= (sw_sync != q_stable);
            end
        end
    end

endmodule

// File: rtl/console_sr_regs.sv
// Console switch (read) / display (write) register on the I/O page.
module console_sr_regs
    import console_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 13,
    parameter logic [ADDR_W-1:0] REG_ADDR = ADDR_W'(CONSOLE_SR_ADDR),
    parameter int                DEBOUNCE = 1023
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] iopage_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              iopage_rd,
    input  logic              iopage_wr,
    input  logic              iopage_byte_op,
    output logic [DATA_W-1:0] data_out,
    output logic              decode,
    input  logic [DATA_W-1:0] switches,
    output logic [DATA_W-1:0] display,
    output logic              display_strobe,
    output logic              sw_change
);

    localparam logic [DATA_W-1:0] LO_MASK = DATA_W'({LANE_W{1'b1}});

    logic [DATA_W-1:0] sw_stable;
    logic [DATA_W-1:0] wr_mask;
    wr_kind_e          kind;

    // Reads are purely combinational, so the read strobe carries no information here.
    logic unused_rd;
    assign unused_rd = iopage_rd;

    sr_debounce #(
        .W        (DATA_W),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk      (clk),
        .reset_n  (reset_n),
        .d_async  (switches),
        .q_stable (sw_stable),
        .changed  (sw_change)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        decode   = (iopage_addr[ADDR_W-1:1] == REG_ADDR[ADDR_W-1:1]);
        data_out = decode ? sw_stable : '0;
        kind     = wr_kind(iopage_wr && decode, iopage_byte_op, iopage_addr[0]);
        wr_mask  = '0;
        case (kind)
            WR_WORD: wr_mask = '1;
            WR_LO:   wr_mask = LO_MASK;
            WR_HI:   wr_mask = ~LO_MASK;
            default: wr_mask = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            display        <= '0;
            display_strobe <= 1'b0;
        end else begin
            display_strobe <= (kind != WR_NONE);
            if (kind != WR_NONE) begin
                display <= (display & ~wr_mask) | (data_in & wr_mask);
            end
        end
    end

endmodule

// File: tb/tb_console_sr_regs.sv
// Directed bench: register access table plus reset, latency, bounce and no-debounce sequences.
module tb_console_sr_regs;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [12:0] iopage_addr;
    logic [15:0] data_in;
    logic        iopage_rd, iopage_wr, iopage_byte_op;
    logic [15:0] sw, sw8, sw0;

    logic [15:0] data_out, display;
    logic        decode, display_strobe, sw_change;
    logic [15:0] data_out8, display8;
    logic        decode8, display_strobe8, sw_change8;
    logic [15:0] data_out0, display0;
    logic        decode0, display_strobe0, sw_change0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    console_sr_regs dut (
        .clk(clk), .reset_n(reset_n), .iopage_addr(iopage_addr), .data_in(data_in),
        .iopage_rd(iopage_rd), .iopage_wr(iopage_wr), .iopage_byte_op(iopage_byte_op),
        .data_out(data_out), .decode(decode), .switches(sw), .display(display),
        .display_strobe(display_strobe), .sw_change(sw_change)
    );

    console_sr_regs #(.DEBOUNCE(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .iopage_addr(iopage_addr), .data_in(data_in),
        .iopage_rd(iopage_rd), .iopage_wr(iopage_wr), .iopage_byte_op(iopage_byte_op),
        .data_out(data_out8), .decode(decode8), .switches(sw8), .display(display8),
        .display_strobe(display_strobe8), .sw_change(sw_change8)
    );

    console_sr_regs #(.DEBOUNCE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .iopage_addr(iopage_addr), .data_in(data_in),
        .iopage_rd(iopage_rd), .iopage_wr(iopage_wr), .iopage_byte_op(iopage_byte_op),
        .data_out(data_out0), .decode(decode0), .switches(sw0), .display(display0),
        .display_strobe(display_strobe0), .sw_change(sw_change0)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [12:0] addr;
        logic [15:0] data;
        logic        byte_op;
        logic        wr;
        logic        rd;
        logic [15:0] exp_display;
        logic        exp_strobe;
        logic        exp_decode;
    } vec_t;

    localparam logic [15:0] SW_VAL = 16'o123456;

    vec_t vecs[10];

    initial begin
        int first_nz, pulses, pulse_at;

        vecs[0] = '{13'o17570, 16'o177777, 1'b0, 1'b1, 1'b0, 16'o177777, 1'b1, 1'b1};
        vecs[1] = '{13'o17571, 16'o052000, 1'b1, 1'b1, 1'b0, 16'o052377, 1'b1, 1'b1};
        vecs[2] = '{13'o17570, 16'hFF00,   1'b0, 1'b1, 1'b0, 16'hFF00,   1'b1, 1'b1};
        vecs[3] = '{13'o17570, 16'h00A5,   1'b1, 1'b1, 1'b0, 16'hFFA5,   1'b1, 1'b1};
        vecs[4] = '{13'o17566, 16'h1234,   1'b0, 1'b1, 1'b0, 16'hFFA5,   1'b0, 1'b0};
        vecs[5] = '{13'o17572, 16'h1234,   1'b0, 1'b1, 1'b1, 16'hFFA5,   1'b0, 1'b0};
        vecs[6] = '{13'o17570, 16'h0000,   1'b0, 1'b0, 1'b1, 16'hFFA5,   1'b0, 1'b1};
        vecs[7] = '{13'o17570, 16'h1234,   1'b1, 1'b1, 1'b0, 16'hFF34,   1'b1, 1'b1};
        vecs[8] = '{13'o17571, 16'hAB00,   1'b1, 1'b1, 1'b0, 16'hAB34,   1'b1, 1'b1};
        vecs[9] = '{13'o17570, 16'h0F0F,   1'b0, 1'b1, 1'b1, 16'h0F0F,   1'b1, 1'b1};

        reset_n = 1'b0;
        iopage_addr = 13'o17570;
        data_in = '0;
        iopage_rd = 1'b0; iopage_wr = 1'b0; iopage_byte_op = 1'b0;
        sw = '0; sw8 = '0; sw0 = '0;

        // Reset state
        repeat (3) tick();
        check("rst_decode", 32'(decode), 32'd1);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_display", 32'(display), 32'd0);
        check("rst_strobe", 32'(display_strobe), 32'd0);
        check("rst_sw_change", 32'(sw_change), 32'd0);
        reset_n = 1'b1;

        // Traffic, then reset asserted mid-debounce with a write pending
        iopage_wr = 1'b1; data_in = 16'h1111;
        tick();
        check("pre_display", 32'(display), 32'h1111);
        check("pre_strobe", 32'(display_strobe), 32'd1);
        iopage_wr = 1'b0;
        sw = SW_VAL;
        repeat (500) tick();
        check("mid_data_out", 32'(data_out), 32'd0);
        iopage_wr = 1'b1; data_in = 16'h2222;
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_display", 32'(display), 32'd0);
        check("mid_rst_strobe", 32'(display_strobe), 32'd0);
        check("mid_rst_data_out", 32'(data_out), 32'd0);
        check("mid_rst_sw_change", 32'(sw_change), 32'd0);
        repeat (2) tick();
        check("rst_hold_display", 32'(display), 32'd0);
        iopage_wr = 1'b0;
        reset_n = 1'b1;

        // Read latency: switches already held, so release acts as a clean edge
        first_nz = 0; pulses = 0; pulse_at = 0;
        for (int i = 1; i <= 1100; i++) begin
            tick();
            if (i == 1) begin
                check("post_rst_display", 32'(display), 32'd0);
                check("post_rst_strobe", 32'(display_strobe), 32'd0);
            end
            if (first_nz == 0 && data_out != 16'd0) first_nz = i;
            if (sw_change) begin
                pulses++;
                pulse_at = i;
            end
        end
        check("read_latency", 32'(first_nz), 32'd1027);
        check("read_pulses", 32'(pulses), 32'd1);
        check("read_pulse_at", 32'(pulse_at), 32'd1027);
        check("read_value", 32'(data_out), 32'(SW_VAL));

        // Register access table
        for (int v = 0; v < 10; v++) begin
            iopage_addr = vecs[v].addr;
            data_in = vecs[v].data;
            iopage_byte_op = vecs[v].byte_op;
            iopage_wr = vecs[v].wr;
            iopage_rd = vecs[v].rd;
            #1;
            check($sformatf("vec%0d_decode", v), 32'(decode), 32'(vecs[v].exp_decode));
            check($sformatf("vec%0d_data_out", v), 32'(data_out),
                  vecs[v].exp_decode ? 32'(SW_VAL) : 32'd0);
            tick();
            check($sformatf("vec%0d_display", v), 32'(display), 32'(vecs[v].exp_display));
            check($sformatf("vec%0d_strobe", v), 32'(display_strobe), 32'(vecs[v].exp_strobe));
        end
        iopage_wr = 1'b0; iopage_rd = 1'b0; iopage_byte_op = 1'b0;
        iopage_addr = 13'o17570;
        tick();
        check("strobe_one_cycle", 32'(display_strobe), 32'd0);
        check("sw_unchanged_by_writes", 32'(data_out), 32'(SW_VAL));

        // Bounce on the DEBOUNCE=8 instance: only the final level may be accepted
        pulses = 0;
        for (int t = 0; t < 5; t++) begin
            sw8[0] = (t % 2 == 0);
            if (t < 4) begin
                for (int k = 0; k < 5; k++) begin
                    tick();
                    if (sw_change8) pulses++;
                end
            end
        end
        first_nz = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (first_nz == 0 && data_out8[0]) first_nz = i;
            if (sw_change8) pulses++;
        end
        check("bounce_latency", 32'(first_nz), 32'd12);
        check("bounce_pulses", 32'(pulses), 32'd1);
        check("bounce_value", 32'(data_out8), 32'h0001);

        // DEBOUNCE=0 instance with a simultaneous read and write
        sw0 = 16'hBEEF;
        iopage_rd = 1'b1; iopage_wr = 1'b1; data_in = 16'h5A5A;
        for (int i = 1; i <= 4; i++) begin
            tick();
            iopage_wr = 1'b0;
            case (i)
                1: begin
                    check("nd_display", 32'(display0), 32'h5A5A);
                    check("nd_strobe1", 32'(display_strobe0), 32'd1);
                    check("nd_data_out1", 32'(data_out0), 32'd0);
                end
                2: begin
                    check("nd_strobe2", 32'(display_strobe0), 32'd0);
                    check("nd_data_out2", 32'(data_out0), 32'd0);
                    check("nd_change2", 32'(sw_change0), 32'd0);
                end
                3: begin
                    check("nd_data_out3", 32'(data_out0), 32'hBEEF);
                    check("nd_change3", 32'(sw_change0), 32'd1);
                end
                default: begin
                    check("nd_change4", 32'(sw_change0), 32'd0);
                    check("nd_display_hold", 32'(display0), 32'h5A5A);
                end
            endcase
        end
        iopage_rd = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
